// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with a registered valid/ready output stage.
// Optional packet locking is enabled by defining RR_ARB_MUX_LOCK_EN (adds in_last).
module rr_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan
);

  // Handshake: a beat moves on a channel when valid && ready are both high on a
  // rising edge; in_ready is only raised for the winner while the output can load.
  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_next;
  logic [WIDTH-1:0] chan_data [CHANNELS];
  logic [CHANNELS-1:0] elig;
  logic             load, found, grant;
  logic [SEL_W-1:0] winner;
  int               idx;

`ifdef RR_ARB_MUX_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
  lock_state_t      lock_q, lock_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Forcing overrides any lock for its cycle; an out-of-range force_sel matches nothing.
  always_comb begin
    elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (force_en) elig[i] = in_valid[i] && (int'(force_sel) == i);
`ifdef RR_ARB_MUX_LOCK_EN
      else if (lock_q == LOCKED) elig[i] = in_valid[i] && (int'(lock_chan_q) == i);
`endif
      else elig[i] = in_valid[i];
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(ptr_q) + k) % CHANNELS;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = SEL_W'(idx);
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign load      = !out_valid || out_ready;
  assign grant     = !rst && load && found;
  assign ptr_next  = SEL_W'((int'(winner) + 1) % CHANNELS);

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (load) state_d = found ? FULL : EMPTY;
  end

`ifdef RR_ARB_MUX_LOCK_EN
  always_comb begin
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
    if (grant && !force_en) begin
      if (lock_q == LOCKED) begin
        if (in_last[winner]) lock_d = UNLOCKED;
      end else if (!in_last[winner]) begin
        lock_d      = LOCKED;
        lock_chan_d = winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= UNLOCKED;
      lock_chan_q <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      out_data <= '0;
      out_chan <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        out_data <= chan_data[winner];
        out_chan <= winner;
        if (!force_en) ptr_q <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed plus randomized bench for rr_arb_mux (4 channels, 32-bit data) against a
// behavioural model of the arbitration rules; lock steps run when RR_ARB_MUX_LOCK_EN is set.
module tb_rr_arb_mux;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           force_en;
  logic [1:0]     force_sel;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [N-1:0]   in_last = '1;
`endif

  rr_arb_mux #(.WIDTH(W), .CHANNELS(N), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_last(in_last),
`endif
    .in_data(in_data), .in_ready(in_ready), .force_en(force_en),
    .force_sel(force_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  // Reference state: what the output register should hold and where priority starts.
  int             n_total = 0;
  int             n_pass  = 0;
  bit             use_model = 1'b1;
  int             m_ptr;
  bit             m_valid;
  logic [W-1:0]   m_data;
  int             m_chan;
  logic [W+1:0]   exp_q[$];

  localparam logic [N*W-1:0] D_AX = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '1; in_data = D_AX; force_en = 1'b0; force_sel = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_chan", 64'(out_chan), 64'd0);
    rst = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_chan = 0;
    exp_q.delete();
  endtask

  // One clock: apply inputs, check the grant, clock, check the output register.
  task automatic step(input logic [N-1:0] v, input logic fe, input logic [1:0] fs,
                      input logic ordy, input logic [N*W-1:0] d);
    bit           ld, any;
    int           win, best;
    logic [N-1:0] exp_rdy;
    logic [W+1:0] beat;
    in_valid = v; force_en = fe; force_sel = fs; out_ready = ordy; in_data = d;
    #1;
    ld = !m_valid || ordy;
    any = 1'b0; win = 0; best = N;
    // Winner = eligible channel at the smallest forward distance from the pointer.
    for (int c = 0; c < N; c++) begin
      if (v[c] && (!fe || c == int'(fs)) && ((c - m_ptr + N) % N) < best) begin
        best = (c - m_ptr + N) % N; win = c; any = 1'b1;
      end
    end
    exp_rdy = (ld && any) ? N'(1 << win) : '0;
    if (use_model) begin
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (m_valid && ordy) begin
        if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else begin
          beat = exp_q.pop_front();
          chk("sb_beat", 64'({out_chan, out_data}), 64'(beat));
        end
      end
    end
    @(posedge clk); #1;
    if (ld) begin
      if (any) begin
        m_valid = 1'b1; m_data = d[win*W +: W]; m_chan = win;
        exp_q.push_back({2'(win), d[win*W +: W]});
        if (!fe) m_ptr = (win + 1) % N;
      end else m_valid = 1'b0;
    end
    if (use_model) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_chan", 64'(out_chan), 64'(m_chan));
      end
    end
  endtask

  initial begin
    logic [N*W-1:0] d;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b0, 2'd0, 1'b1, D_AX);
      chk("rr_chan", 64'(out_chan), 64'(i % N));
      chk("rr_data", 64'(out_data), 64'(32'hA0 + (i % N)));
    end

    step(4'hF, 1'b0, 2'd0, 1'b1, D_AX);
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b0, 2'd0, 1'b0, D_AX);
      chk("bp_data", 64'(out_data), 64'hA1);
      chk("bp_chan", 64'(out_chan), 64'd1);
    end
    in_valid = 4'hF; out_ready = 1'b0; #1;
    chk("bp_stall_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1; #1;
    chk("bp_release_ready", 64'(in_ready), 64'b0100);
    step(4'hF, 1'b0, 2'd0, 1'b1, D_AX);
    chk("bp_next_chan", 64'(out_chan), 64'd2);
    step(4'hF, 1'b0, 2'd0, 1'b1, D_AX);

    d = D_AX; d[2*W +: W] = 32'h55;
    step(4'b0100, 1'b1, 2'd2, 1'b1, d);
    chk("force_chan", 64'(out_chan), 64'd2);
    chk("force_data", 64'(out_data), 64'h55);
    step(4'hF, 1'b0, 2'd0, 1'b1, D_AX);
    chk("force_ptr_kept", 64'(out_chan), 64'd0);

    do_reset();
    step(4'b1000, 1'b0, 2'd0, 1'b1, D_AX);
    chk("sparse_chan", 64'(out_chan), 64'd3);
    step(4'b0000, 1'b0, 2'd0, 1'b1, D_AX);
    chk("empty_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), d);
    end
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 2'd0, 1'b1, D_AX);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);

`ifdef RR_ARB_MUX_LOCK_EN
    do_reset();
    use_model = 1'b0;
    d = '0; d[1*W +: W] = 32'h11; d[2*W +: W] = 32'h22;
    in_last = 4'b1101;
    step(4'b0110, 1'b0, 2'd0, 1'b1, d);
    chk("lock_beat0", 64'(out_chan), 64'd1);
    step(4'b0110, 1'b0, 2'd0, 1'b1, d);
    chk("lock_beat1", 64'(out_chan), 64'd1);
    in_last = 4'hF;
    step(4'b0110, 1'b0, 2'd0, 1'b1, d);
    chk("lock_beat2", 64'(out_chan), 64'd1);
    step(4'b0110, 1'b0, 2'd0, 1'b1, d);
    chk("lock_release", 64'(out_chan), 64'd2);
    chk("lock_release_data", 64'(out_data), 64'h22);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel arbitrating multiplexer with a registered valid/ready output stage. It is the successor to the fixed 4:1 combinational select mux. It merges several producer channels (e.g. writeback sources, memory request ports) onto one consumer, choosing between them by round-robin arbitration or by a forced select. Output is registered for one-cycle latency at full throughput.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select/channel-id width; must equal ceil(log2(CHANNELS))

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  CHANNELS  per-channel request valid
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  one-hot (or zero) grant; combinational
- force_en  input  1  1 = fixed-select mode, no arbitration
- force_sel  input  SEL_W  channel used when force_en=1
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  registered id of the source channel

## Operation
- Output stage states: EMPTY (out_valid=0), FULL (out_valid=1).
- load = !out_valid || out_ready. A new beat is captured only when load=1.
- Eligible set: with force_en=0, all i with in_valid[i]. With force_en=1, only force_sel, and only if in_valid[force_sel]. If force_sel >= CHANNELS, nothing is eligible.
- Winner: the first eligible channel scanning from ptr upward, wrapping modulo CHANNELS.
- in_ready[winner]=1 iff load=1 and an eligible channel exists. All other bits are 0. in_ready never depends on in_valid of non-winning channels beyond the scan.
- Capture, on a clock with a grant: out_data<=in_data[winner], out_chan<=winner, out_valid<=1.
- Pointer update: ptr<=(winner+1) mod CHANNELS, only when the grant is in round-robin mode. Forced grants leave ptr unchanged.
- If load=1 and nothing is eligible: out_valid<=0. out_data and out_chan hold their values.
- If load=0: all output registers hold, and in_ready=0.
- Reset: out_valid=0, out_data=0, out_chan=0, ptr=0 (channel 0 highest priority). Reset mid-transfer discards the held beat. in_ready is 0 during reset.

## Timing
- Latency: grant in cycle N, out_valid/out_data visible in cycle N+1.
- Throughput: one beat per cycle while out_ready=1. There are no bubbles on a simultaneous drain and refill.
- Backpressure: out_valid=1 with out_ready=0 stalls. out_data and out_chan must stay stable until accepted.
- Fairness: with all channels continuously valid in round-robin mode, grants rotate 0,1,...,CHANNELS-1,0 with no repeats.
- force_en and force_sel are sampled combinationally each cycle and may change on any cycle.

## Configuration
- RR_ARB_MUX_LOCK_EN defined:
  - adds an input port in_last (CHANNELS bits), and the arbiter gains states UNLOCKED and LOCKED(ch).
  - When a non-last beat is granted in round-robin mode, the arbiter enters LOCKED on that channel. Only that channel is eligible until its beat with in_last=1 is granted, which returns the arbiter to UNLOCKED.
  - force_en=1 overrides the lock for its cycle but does not clear it.
  - rst returns the arbiter to UNLOCKED.
- RR_ARB_MUX_LOCK_EN undefined: there is no in_last port, and every beat is arbitrated independently.

## Test plan
- Reset: assert rst for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_chan=0. First grant after release goes to channel 0.
- Round-robin: CHANNELS=4, all valid, out_ready=1, in_data[i]=0xA0+i -> out_chan sequence 0,1,2,3,0 on consecutive cycles, with out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
- Backpressure: hold out_ready=0 for 3 cycles after a beat with out_data=0xA1 -> out_data stays 0xA1, in_ready=0. Raising out_ready yields the next grant in that same cycle.
- Forced select: force_en=1, force_sel=2, only in_valid[2]=1 with data 0x55 -> out_chan=2, out_data=0x55 one cycle later. ptr is unchanged, so the next round-robin grant still starts from the prior pointer.
- Sparse and empty input: only channel 3 valid, ptr=0 -> channel 3 is granted. Drop all valid with out_ready=1 -> out_valid falls to 0 next cycle.
- Lock (with RR_ARB_MUX_LOCK_EN): channel 1 sends 3 beats with in_last on the third, while channel 2 is valid throughout -> three consecutive out_chan=1 beats, then out_chan=2.
